// File: rtl/sccb_cfg_pkg.sv
// Shared definitions for the SCCB register configuration sequencer:
// state encoding, default device id, table entry layout, bus drive decode.
package sccb_cfg_pkg;

    localparam logic [7:0] DEF_DEV_ID = 8'h78;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 8;
    localparam int ENTRY_W = ADDR_W + DATA_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } reg_entry_t;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_BYTE      = 3'd2;
    localparam logic [2:0] S_XBIT      = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_GAP       = 3'd5;
    localparam logic [2:0] S_WAIT_SRST = 3'd6;
    localparam logic [2:0] S_DONE      = 3'd7;

    // Returns {sioc, siod_oe, siod_o} for a state and quarter-bit phase.
    function automatic logic [2:0] bus_drive(
        input logic [2:0] st,
        input logic [1:0] q,
        input logic       sd
    );
        logic [2:0] drv;
        drv = 3'b101;
        case (st)
            S_START: begin
                case (q)
                    2'd0:    drv = 3'b101;
                    2'd1:    drv = 3'b110;
                    default: drv = 3'b010;
                endcase
            end
            S_BYTE:  drv = {q[1], 1'b1, sd};
            S_XBIT:  drv = {q[1], 2'b01};
            S_STOP: begin
                case (q)
                    2'd0:    drv = 3'b010;
                    2'd1:    drv = 3'b110;
                    default: drv = 3'b101;
                endcase
            end
            default: drv = 3'b101;
        endcase
        return drv;
    endfunction

endpackage

// File: rtl/sccb_reg_rom.sv
// Sensor register table: index -> {addr[15:0], data[7:0]}.
// Entry 0 is the soft reset; indices beyond the list repeat a benign wake write.
module sccb_reg_rom
    import sccb_cfg_pkg::*;
(
    input  logic [7:0]         index,
    output logic [ENTRY_W-1:0] entry
);

    always_comb begin
        case (index)
            8'd0:    entry = 24'h3008_82;
            8'd1:    entry = 24'h3103_11;
            8'd2:    entry = 24'h3008_42;
            8'd3:    entry = 24'h3103_03;
            8'd4:    entry = 24'h3017_ff;
            8'd5:    entry = 24'h3018_ff;
            8'd6:    entry = 24'h3034_1a;
            8'd7:    entry = 24'h3037_13;
            8'd8:    entry = 24'h3108_01;
            8'd9:    entry = 24'h3630_36;
            8'd10:   entry = 24'h3631_0e;
            8'd11:   entry = 24'h3632_e2;
            8'd12:   entry = 24'h3633_12;
            8'd13:   entry = 24'h3621_e0;
            8'd14:   entry = 24'h3704_a0;
            8'd15:   entry = 24'h3703_5a;
            default: entry = 24'h3008_02;
        endcase
    end

endmodule

// File: rtl/sccb_cfg.sv
// SCCB register configuration sequencer: after power-up, writes every
// table entry as a 3-phase SCCB write, with a settle wait after soft reset.
module sccb_cfg
    import sccb_cfg_pkg::*;
#(
    parameter int         CLK_FREQ  = 50_000_000,
    parameter int         SCCB_FREQ = 100_000,
    parameter logic [7:0] DEV_ID    = DEF_DEV_ID,
    parameter logic [7:0] REG_NUM   = 8'd250,
    parameter int         SRST_WAIT = 250_000,
    parameter int         GAP_CYC   = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       power_done,
    output logic       sioc,
    output logic       siod_o,
    output logic       siod_oe,
    output logic       cfg_busy,
    output logic       cfg_done,
    output logic [7:0] reg_index
);

    localparam int DIV_RAW  = CLK_FREQ / (4 * SCCB_FREQ);
    localparam int DIV      = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W    = $clog2(DIV + 1);
    localparam int WAIT_MAX = (SRST_WAIT > GAP_CYC) ? SRST_WAIT : GAP_CYC;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [WAIT_W-1:0] GAP_LAST  = WAIT_W'(GAP_CYC - 1);
    localparam logic [WAIT_W-1:0] SRST_LAST = WAIT_W'(SRST_WAIT - 1);

    logic [2:0]        state, nxt_state;
    logic [1:0]        q, nxt_q;
    logic [2:0]        bit_cnt, nxt_bit;
    logic [1:0]        byte_cnt, nxt_byte;
    logic [DIV_W-1:0]  div_cnt, nxt_div;
    logic [WAIT_W-1:0] wait_cnt, nxt_wait;
    logic [23:0]       shreg, nxt_shreg;
    logic [7:0]        nxt_idx;
    logic              nxt_sd;
    logic [2:0]        drv;
    logic              tick;
    logic              gap_end;
    logic              aborting;
    reg_entry_t        rom_q;

    assign tick     = (div_cnt == DIV_LAST);
    assign gap_end  = (state == S_GAP) && (wait_cnt == GAP_LAST);
    assign aborting = !power_done && (state != S_IDLE) && (state != S_DONE);

    // Index is resolved ahead of the FSM so the table lookup sees the entry
    // that the next START will latch.
    always_comb begin
        nxt_idx = reg_index;
        if (aborting)
            nxt_idx = 8'd0;
        else if (gap_end)
            nxt_idx = reg_index + 8'd1;
    end

    sccb_reg_rom u_rom (
        .index (nxt_idx),
        .entry (rom_q)
    );

    always_comb begin
        nxt_state = state;
        nxt_q     = q;
        nxt_bit   = bit_cnt;
        nxt_byte  = byte_cnt;
        nxt_shreg = shreg;
        nxt_wait  = '0;
        unique case (state)
            S_IDLE: begin
                if (power_done && !cfg_done)
                    nxt_state = S_START;
            end
            S_START: begin
                if (tick) begin
                    nxt_q = q + 2'd1;
                    if (q == 2'd3) begin
                        nxt_state = S_BYTE;
                        nxt_byte  = 2'd0;
                        nxt_bit   = 3'd0;
                    end
                end
            end
            S_BYTE: begin
                if (tick) begin
                    nxt_q = q + 2'd1;
                    if (q == 2'd3) begin
                        if (byte_cnt != 2'd0)
                            nxt_shreg = {shreg[22:0], 1'b0};
                        if (bit_cnt == 3'd7)
                            nxt_state = S_XBIT;
                        else
                            nxt_bit = bit_cnt + 3'd1;
                    end
                end
            end
            S_XBIT: begin
                if (tick) begin
                    nxt_q = q + 2'd1;
                    if (q == 2'd3) begin
                        if (byte_cnt == 2'd3) begin
                            nxt_state = S_STOP;
                        end else begin
                            nxt_state = S_BYTE;
                            nxt_byte  = byte_cnt + 2'd1;
                            nxt_bit   = 3'd0;
                        end
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    nxt_q = q + 2'd1;
                    if (q == 2'd3)
                        nxt_state = S_GAP;
                end
            end
            S_GAP: begin
                nxt_wait = wait_cnt + 1'b1;
                if (gap_end) begin
                    if (reg_index == 8'd0)
                        nxt_state = S_WAIT_SRST;
                    else if (nxt_idx == REG_NUM)
                        nxt_state = S_DONE;
                    else
                        nxt_state = S_START;
                end
            end
            S_WAIT_SRST: begin
                nxt_wait = wait_cnt + 1'b1;
                if (wait_cnt == SRST_LAST)
                    nxt_state = (REG_NUM == 8'd1) ? S_DONE : S_START;
            end
            default: begin
                nxt_state = S_DONE;
            end
        endcase

        if (aborting) begin
            nxt_state = S_IDLE;
            nxt_bit   = 3'd0;
            nxt_byte  = 2'd0;
        end

        if (nxt_state != state) begin
            nxt_q    = 2'd0;
            nxt_wait = '0;
        end
        nxt_div = (tick || nxt_state != state) ? '0 : div_cnt + 1'b1;

        if (nxt_state == S_START && state != S_START)
            nxt_shreg = {rom_q.addr, rom_q.data};

        nxt_sd = (nxt_byte == 2'd0) ? DEV_ID[3'd7 - nxt_bit] : nxt_shreg[23];
        drv    = bus_drive(nxt_state, nxt_q, nxt_sd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            q         <= 2'd0;
            bit_cnt   <= 3'd0;
            byte_cnt  <= 2'd0;
            div_cnt   <= '0;
            wait_cnt  <= '0;
            shreg     <= 24'd0;
            reg_index <= 8'd0;
            sioc      <= 1'b1;
            siod_oe   <= 1'b0;
            siod_o    <= 1'b1;
            cfg_busy  <= 1'b0;
            cfg_done  <= 1'b0;
        end else begin
            state     <= nxt_state;
            q         <= nxt_q;
            bit_cnt   <= nxt_bit;
            byte_cnt  <= nxt_byte;
            div_cnt   <= nxt_div;
            wait_cnt  <= nxt_wait;
            shreg     <= nxt_shreg;
            reg_index <= nxt_idx;
            sioc      <= drv[2];
            siod_oe   <= drv[1];
            siod_o    <= drv[0];
            cfg_busy  <= (nxt_state != S_IDLE) && (nxt_state != S_DONE);
            cfg_done  <= (nxt_state == S_DONE);
        end
    end

endmodule

// File: doc/sccb_cfg.md
SCCB_CFG -- requirements
Module: sccb_cfg

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50_000_000, meaning clk frequency in Hz.
REQ-002 The block SHALL have parameter SCCB_FREQ, default 100_000, meaning SIOC bit rate in Hz.
REQ-003 The block SHALL have parameter DEV_ID, default 8'h78, meaning 8-bit SCCB write address.
REQ-004 The block SHALL have parameter REG_NUM, default 8'd250, meaning number of table entries (1..255).
REQ-005 The block SHALL have parameter SRST_WAIT, default 250_000, meaning clk cycles of wait after entry 0 (soft reset, 5 ms at 50 MHz).
REQ-006 The block SHALL have parameter GAP_CYC, default 500, meaning idle clk cycles between transactions.
REQ-007 The block SHALL have port clk  input  1  system clock.
REQ-008 The block SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-009 The block SHALL have port power_done  input  1  sensor power-up sequence complete, level, clk domain.
REQ-010 The block SHALL have port sioc  output  1  SCCB clock, push-pull.
REQ-011 The block SHALL have port siod_o  output  1  SCCB data value, only meaningful while siod_oe=1.
REQ-012 The block SHALL have port siod_oe  output  1  SCCB data drive enable; 0 = released (pull-up).
REQ-013 The block SHALL have port cfg_busy  output  1  transaction sequence in progress.
REQ-014 The block SHALL have port cfg_done  output  1  all REG_NUM entries written, sticky.
REQ-015 The block SHALL have port reg_index  output  8  index of entry currently or next being written.

Function
REQ-016 The block SHALL derive a quarter-bit tick every DIV = CLK_FREQ/(4*SCCB_FREQ) clk cycles (integer division, DIV>=1), from a free counter reset at each state entry.
REQ-017 The FSM SHALL have states IDLE, START, BYTE, XBIT, STOP, GAP, WAIT_SRST, DONE, each advancing only on tick except IDLE/DONE.
REQ-018 IDLE: sioc=1, siod_oe=0; leave to START on the first clk where power_done=1 and cfg_done=0.
REQ-019 START: ticks q0 siod released, q1 siod_oe=1 siod_o=0 (sioc high), q2 sioc=0, q3 -> BYTE with byte_cnt=0.
REQ-020 Bytes per transaction SHALL be, in order: DEV_ID, addr[15:8], addr[7:0], data[7:0], MSB first.
REQ-021 Each data bit SHALL take 4 ticks: q0 sioc=0 and siod_o updated, q1 sioc=0, q2 sioc=1, q3 sioc=1.
REQ-022 XBIT (9th bit) SHALL release siod (siod_oe=0) for its 4 ticks and SHALL NOT sample or check acknowledge.
REQ-023 After XBIT of byte 3 -> STOP, else -> BYTE with byte_cnt+1.
REQ-024 STOP: q0 sioc=0 siod_oe=1 siod_o=0, q1 sioc=1, q2 siod released, q3 -> GAP.
REQ-025 GAP SHALL last GAP_CYC clk cycles, then increment reg_index; if reg_index was 0 -> WAIT_SRST, else if new reg_index==REG_NUM -> DONE, else -> START.
REQ-026 WAIT_SRST SHALL last SRST_WAIT clk cycles then -> START (or DONE if REG_NUM==1).
REQ-027 DONE: cfg_done=1, cfg_busy=0, bus idle; block stays in DONE until reset.
REQ-028 cfg_busy SHALL be 1 in every state except IDLE and DONE.
REQ-029 If power_done falls while in any state other than IDLE/DONE, the FSM SHALL go to IDLE on the next clk: sioc=1, siod_oe=0, reg_index=0, all counters cleared; restart follows REQ-018.
REQ-030 Address/data for reg_index SHALL come from a combinational table lookup, latched into a 24-bit shift register on START entry so table output may change mid-transaction.

Reset
REQ-031 On rst_n=0 the block SHALL asynchronously set: state=IDLE, sioc=1, siod_o=1, siod_oe=0, cfg_busy=0, cfg_done=0, reg_index=0, all counters 0.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding, default DEV_ID, and the 24-bit table-entry field widths.
REQ-033 The register table SHALL be a sub-module sccb_reg_rom (input 8-bit index, output 24-bit {addr,data}), entry 0 = {16'h3008, 8'h82}.
REQ-034 Expected RTL size 150-300 lines excluding table contents.

Verification (CLK_FREQ=400, SCCB_FREQ=100 -> DIV=1, GAP_CYC=4, SRST_WAIT=10, REG_NUM=3)
REQ-035 rst_n low, power_done=0 for 100 cycles -> sioc=1, siod_oe=0, cfg_busy=0, reg_index=0 throughout.
REQ-036 power_done rises -> START within 1 clk; bus monitor decodes bytes 78,30,08,82 with START/STOP framing, each bit high phase = 2 clk.
REQ-037 After entry 0 STOP -> GAP 4 clk + WAIT_SRST 10 clk, reg_index=1, before next START.
REQ-038 Full run -> exactly 3 transactions decoded against sccb_reg_rom, then cfg_done=1, cfg_busy=0 on the clk reg_index reaches 3.
REQ-039 power_done dropped mid byte 2 of entry 1 -> next clk sioc=1, siod_oe=0, reg_index=0; re-raise -> sequence restarts at entry 0.
REQ-040 rst_n asserted mid-transaction -> outputs at reset values the same cycle (asynchronous), no further SIOC edges until power_done.
